// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the miniRV hazard controller: forward-select
// encodings, the shadow-entry flag layout, the bubble entry and the
// forward-priority helper.
package hazard_unit_pkg;

  // EX operand source encodings
  localparam logic [1:0] FWD_SEL_RF  = 2'd0;
  localparam logic [1:0] FWD_SEL_EX  = 2'd1;
  localparam logic [1:0] FWD_SEL_MEM = 2'd2;
  localparam logic [1:0] FWD_SEL_WB  = 2'd3;

  // Per-entry status flags; the rd field width follows REG_AW in the users
  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } entry_flags_t;

  localparam int FLAG_W    = $bits(entry_flags_t);
  localparam int STAGE_CNT = 3;  // EX, MEM, WB

  // An empty slot: nothing in flight, nothing written
  localparam entry_flags_t BUBBLE_FLAGS = '{valid: 1'b0, we: 1'b0, is_load: 1'b0};

  // The youngest producer holds the newest value, so EX beats MEM beats WB
  function automatic logic [1:0] pick_fwd(input logic m_ex, input logic m_mem,
                                          input logic m_wb);
    if (m_ex)       return FWD_SEL_EX;
    else if (m_mem) return FWD_SEL_MEM;
    else if (m_wb)  return FWD_SEL_WB;
    else            return FWD_SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow entry {valid, we, rd, is_load} tracking an in-flight
// instruction. Clear takes priority over load and produces a bubble.
module hazard_stage_reg
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  entry_flags_t      d_flags,
  input  logic [REG_AW-1:0] d_rd,
  output entry_flags_t      q_flags,
  output logic [REG_AW-1:0] q_rd
);

  // Entry register: async clear to a bubble, synchronous clear/load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_flags <= BUBBLE_FLAGS;
      q_rd    <= '0;
    end else if (clear) begin
      q_flags <= BUBBLE_FLAGS;
      q_rd    <= '0;
    end else if (load) begin
      q_flags <= d_flags;
      q_rd    <= d_rd;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage miniRV core. Shadows the
// destination registers of the EX/MEM/WB instructions and produces stall,
// flush and forward-select controls.
// Optional build macro: HAZARD_PERF_EN adds stall/flush event counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int FORWARD = 1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              id_have_inst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_read_rD1,
  input  logic              id_read_rD2,
  input  logic              id_rf_we,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              ex_jump,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_rD1_sel,
  output logic [1:0]        fwd_rD2_sel
);

  // Index 0 = EX, 1 = MEM, 2 = WB
  entry_flags_t      sh_flags [STAGE_CNT];
  logic [REG_AW-1:0] sh_rd    [STAGE_CNT];
  logic [STAGE_CNT-1:0] m1;
  logic [STAGE_CNT-1:0] m2;

  entry_flags_t id_flags;
  logic         hazard;
  logic         stall;
  logic         ex_load_use;

  assign id_flags = '{valid: id_have_inst, we: id_rf_we, is_load: id_is_load};

  genvar gi;
  generate
    for (gi = 0; gi < STAGE_CNT; gi++) begin : g_stage
      if (gi == 0) begin : g_ex
        // EX captures the ID instruction, or a bubble when ID/EX is flushed
        hazard_stage_reg #(.REG_AW(REG_AW)) u_entry (
          .clk     (cpu_clk),
          .rst     (cpu_rst),
          .load    (1'b1),
          .clear   (flush_id_ex),
          .d_flags (id_flags),
          .d_rd    (id_rd),
          .q_flags (sh_flags[gi]),
          .q_rd    (sh_rd[gi])
        );
      end else begin : g_tail
        // MEM and WB simply advance every cycle
        hazard_stage_reg #(.REG_AW(REG_AW)) u_entry (
          .clk     (cpu_clk),
          .rst     (cpu_rst),
          .load    (1'b1),
          .clear   (1'b0),
          .d_flags (sh_flags[gi-1]),
          .d_rd    (sh_rd[gi-1]),
          .q_flags (sh_flags[gi]),
          .q_rd    (sh_rd[gi])
        );
      end

      // x0 is hardwired zero, so it never produces a dependency
      assign m1[gi] = sh_flags[gi].valid & sh_flags[gi].we & (sh_rd[gi] != '0)
                    & (sh_rd[gi] == id_rs1) & id_read_rD1;
      assign m2[gi] = sh_flags[gi].valid & sh_flags[gi].we & (sh_rd[gi] != '0)
                    & (sh_rd[gi] == id_rs2) & id_read_rD2;
    end
  endgenerate

  assign ex_load_use = sh_flags[0].is_load & (m1[0] | m2[0]);

  generate
    if (FORWARD != 0) begin : g_fwd
      // Only a load in EX cannot be bypassed in time
      assign hazard      = id_have_inst & ex_load_use;
      assign fwd_rD1_sel = pick_fwd(m1[0], m1[1], m1[2]);
      assign fwd_rD2_sel = pick_fwd(m2[0], m2[1], m2[2]);
    end else begin : g_nofwd
      // No bypass and no write-through RF: wait until every producer drains
      assign hazard      = id_have_inst & ((|m1) | (|m2));
      assign fwd_rD1_sel = FWD_SEL_RF;
      assign fwd_rD2_sel = FWD_SEL_RF;
    end
  endgenerate

  // A taken jump kills the ID instruction, so it overrides any stall;
  // reset masks the flushes so every control is quiet while held
  assign stall       = hazard & ~ex_jump & ~cpu_rst;
  assign stall_pc    = stall;
  assign stall_if_id = stall;
  assign flush_if_id = ex_jump & ~cpu_rst;
  assign flush_id_ex = (ex_jump | hazard) & ~cpu_rst;

  // is_load is only consulted in EX; the copies in MEM/WB travel along unused
  logic unused_flags;
  assign unused_flags = &{1'b0, sh_flags[1].is_load, sh_flags[2].is_load, ex_load_use};

`ifdef HAZARD_PERF_EN
  // Event counters: cycles spent stalled and cycles spent flushing IF/ID
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_if_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one forwarding instance and one
// stall-only instance driven by the same ID-stage stimulus.
module tb_hazard_unit;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic       id_have_inst;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_read_rD1, id_read_rD2, id_rf_we, id_is_load;
  logic       ex_jump;

  logic       f_stall_pc, f_stall_if_id, f_flush_if_id, f_flush_id_ex;
  logic [1:0] f_fwd1, f_fwd2;
  logic       n_stall_pc, n_stall_if_id, n_flush_if_id, n_flush_id_ex;
  logic [1:0] n_fwd1, n_fwd2;
`ifdef HAZARD_PERF_EN
  logic [31:0] f_perf_stall, f_perf_flush, n_perf_stall, n_perf_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cpu_clk = ~cpu_clk;

  hazard_unit #(.REG_AW(5), .FORWARD(1)) u_fwd (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .id_have_inst (id_have_inst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_read_rD1  (id_read_rD1),
    .id_read_rD2  (id_read_rD2),
    .id_rf_we     (id_rf_we),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .ex_jump      (ex_jump),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (f_perf_stall),
    .perf_flush_cnt (f_perf_flush),
`endif
    .stall_pc     (f_stall_pc),
    .stall_if_id  (f_stall_if_id),
    .flush_if_id  (f_flush_if_id),
    .flush_id_ex  (f_flush_id_ex),
    .fwd_rD1_sel  (f_fwd1),
    .fwd_rD2_sel  (f_fwd2)
  );

  hazard_unit #(.REG_AW(5), .FORWARD(0)) u_nofwd (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .id_have_inst (id_have_inst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_read_rD1  (id_read_rD1),
    .id_read_rD2  (id_read_rD2),
    .id_rf_we     (id_rf_we),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .ex_jump      (ex_jump),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (n_perf_stall),
    .perf_flush_cnt (n_perf_flush),
`endif
    .stall_pc     (n_stall_pc),
    .stall_if_id  (n_stall_if_id),
    .flush_if_id  (n_flush_if_id),
    .flush_id_ex  (n_flush_id_ex),
    .fwd_rD1_sel  (n_fwd1),
    .fwd_rD2_sel  (n_fwd2)
  );

  // Drive the ID-stage instruction fields
  task automatic set_id(input logic have, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic r1, input logic r2, input logic we,
                        input logic [4:0] rd, input logic ld);
    id_have_inst = have;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_read_rD1  = r1;
    id_read_rD2  = r2;
    id_rf_we     = we;
    id_rd        = rd;
    id_is_load   = ld;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    ex_jump = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ex_jump = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cpu_rst = 1'b1;
    step();
    n_checks++;
    if ({f_stall_pc, f_stall_if_id, f_flush_if_id, f_flush_id_ex, f_fwd1, f_fwd2} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_fwd: outputs=%b expected=00000000",
               {f_stall_pc, f_stall_if_id, f_flush_if_id, f_flush_id_ex, f_fwd1, f_fwd2});
    end
    n_checks++;
    if ({n_stall_pc, n_stall_if_id, n_flush_if_id, n_flush_id_ex, n_fwd1, n_fwd2} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_nofwd: outputs=%b expected=00000000",
               {n_stall_pc, n_stall_if_id, n_flush_if_id, n_flush_id_ex, n_fwd1, n_fwd2});
    end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (f_perf_stall !== 32'd0 || f_perf_flush !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: stall_cnt=%0d flush_cnt=%0d expected=0/0", f_perf_stall, f_perf_flush);
    end
`endif
    cpu_rst = 1'b0;
    #1;
    $display("test_reset: done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);  // lw x5
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);  // add x6,x5,x1
    #1;
    n_checks++;
    if ({f_stall_pc, f_stall_if_id, f_flush_id_ex, f_flush_if_id} !== 4'b1110) begin
      n_fail++;
      $display("FAIL load_use_stall: {spc,sifid,fidex,fifid}=%b expected=1110",
               {f_stall_pc, f_stall_if_id, f_flush_id_ex, f_flush_if_id});
    end
    step();
    n_checks++;
    if (f_stall_pc !== 1'b0 || f_flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_release: stall_pc=%b flush_id_ex=%b expected=0/0", f_stall_pc, f_flush_id_ex);
    end
    n_checks++;
    if (f_fwd1 !== 2'd2 || f_fwd2 !== 2'd0) begin
      n_fail++;
      $display("FAIL load_use_fwd: fwd1=%0d fwd2=%0d expected=2/0", f_fwd1, f_fwd2);
    end
    $display("test_load_use: done");
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);  // add x3
    step();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);  // sub x4,x3,x3
    #1;
    n_checks++;
    if (f_stall_pc !== 1'b0 || f_fwd1 !== 2'd1 || f_fwd2 !== 2'd1) begin
      n_fail++;
      $display("FAIL alu_chain: stall=%b fwd1=%0d fwd2=%0d expected=0/1/1", f_stall_pc, f_fwd1, f_fwd2);
    end
    $display("test_alu_chain: done");
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);  // add x7
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);  // empty slot
    step();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);  // probe x7 in MEM
    #1;
    n_checks++;
    if (f_fwd1 !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_mem: fwd1=%0d expected=2", f_fwd1);
    end
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);  // add x7 again
    step();
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);  // x7 in EX and WB
    #1;
    n_checks++;
    if (f_fwd1 !== 2'd1 || f_fwd2 !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_ex_over_wb: fwd1=%0d fwd2=%0d expected=1/0", f_fwd1, f_fwd2);
    end
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);  // lw x0
    step();
    set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);  // reads x0 and x7
    #1;
    n_checks++;
    if (f_fwd1 !== 2'd0 || f_stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_no_match: fwd1=%0d stall=%b expected=0/0", f_fwd1, f_stall_pc);
    end
    n_checks++;
    if (f_fwd2 !== 2'd2) begin
      n_fail++;
      $display("FAIL x7_in_mem: fwd2=%0d expected=2", f_fwd2);
    end
    $display("test_priority: done");
  endtask

  task automatic test_jump_vs_stall();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);  // lw x5
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);  // add x6,x5,x1
    ex_jump = 1'b1;
    #1;
    n_checks++;
    if ({f_flush_if_id, f_flush_id_ex, f_stall_pc, f_stall_if_id} !== 4'b1100) begin
      n_fail++;
      $display("FAIL jump_wins: {fifid,fidex,spc,sifid}=%b expected=1100",
               {f_flush_if_id, f_flush_id_ex, f_stall_pc, f_stall_if_id});
    end
    step();
    ex_jump = 1'b0;
    set_id(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);  // reads x6 and x5
    #1;
    n_checks++;
    if (f_fwd1 !== 2'd0 || f_fwd2 !== 2'd2) begin
      n_fail++;
      $display("FAIL jump_bubble: fwd1=%0d fwd2=%0d expected=0/2", f_fwd1, f_fwd2);
    end
    $display("test_jump_vs_stall: done");
  endtask

  task automatic test_no_inst();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);  // lw x5
    step();
    set_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);  // invalid slot
    #1;
    n_checks++;
    if (f_stall_pc !== 1'b0 || f_flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL no_inst_stall: stall=%b flush_id_ex=%b expected=0/0", f_stall_pc, f_flush_id_ex);
    end
    step();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);  // reads x8
    #1;
    n_checks++;
    if (f_fwd1 !== 2'd0) begin
      n_fail++;
      $display("FAIL no_inst_invalid_ex: fwd1=%0d expected=0", f_fwd1);
    end
    $display("test_no_inst: done");
  endtask

  task automatic test_no_forward();
    int stalls;
    bit released;
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);  // addi x9
    step();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0); // uses x9
    #1;
    n_checks++;
    if (n_fwd1 !== 2'd0 || f_fwd1 !== 2'd1 || f_stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL nofwd_first: n_fwd1=%0d f_fwd1=%0d f_stall=%b expected=0/1/0",
               n_fwd1, f_fwd1, f_stall_pc);
    end
    stalls = 0;
    released = 1'b0;
    for (int i = 0; i < 8 && !released; i++) begin
      if (n_stall_pc === 1'b1 && n_flush_id_ex === 1'b1 && n_stall_if_id === 1'b1) begin
        stalls++;
        step();
      end else begin
        released = 1'b1;
      end
    end
    n_checks++;
    if (!released || stalls != 3) begin
      n_fail++;
      $display("FAIL nofwd_stall_count: stalls=%0d released=%0d expected=3/1", stalls, released);
    end
    n_checks++;
    if (n_fwd1 !== 2'd0 || n_stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL nofwd_release: fwd1=%0d stall=%b expected=0/0", n_fwd1, n_stall_pc);
    end
    $display("test_no_forward: stalls=%0d", stalls);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);  // lw x5
    step();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);  // uses x5
    #1;
    n_checks++;
    if (f_stall_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: stall=%b expected=1", f_stall_pc);
    end
    #1;
    cpu_rst = 1'b1;
    #1;
    n_checks++;
    if ({f_stall_pc, f_stall_if_id, f_flush_if_id, f_flush_id_ex, f_fwd1, f_fwd2} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clear: outputs=%b expected=00000000",
               {f_stall_pc, f_stall_if_id, f_flush_if_id, f_flush_id_ex, f_fwd1, f_fwd2});
    end
    #1;
    cpu_rst = 1'b0;
    #1;
    n_checks++;
    if (f_stall_pc !== 1'b0 || f_fwd1 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_after: stall=%b fwd1=%0d expected=0/0", f_stall_pc, f_fwd1);
    end
    step();
    n_checks++;
    if (f_stall_pc !== 1'b0 || n_stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL async_empty_shadow: f_stall=%b n_stall=%b expected=0/0", f_stall_pc, n_stall_pc);
    end
    $display("test_async_reset: done");
  endtask

  initial begin
    cpu_rst = 1'b1;
    ex_jump = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_load_use();
    test_alu_chain();
    test_priority();
    test_jump_vs_stall();
    test_no_inst();
    test_no_forward();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
